pl_bram_lite_slave: RTL and testbench

AXI4-Lite slave register bank that answers the single-beat write/read transactions issued by the VIP master in the block-design bench and by the PS GP port in hardware. It holds NUM_REGS 32-bit software registers at word-aligned offsets from 0x0. Registers are exported as a flat bus to the BRAM-read datapath. Write and read channels are independent state machines with full VALID/READY handshaking and byte-strobe support.

---
 rtl/pl_bram_lite_slave.sv | 205 ++++++++++++++++++++
 tb/tb_pl_bram_lite_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_bram_lite_slave.sv
// AXI4-Lite register bank exporting NUM_REGS 32-bit registers as a flat bus.
// Optional macro PL_BRAM_LITE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module pl_bram_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
    input  logic [2:0]                           s00_axi_awprot,
    input  logic                                 s00_axi_awvalid,
    output logic                                 s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
    input  logic                                 s00_axi_wvalid,
    output logic                                 s00_axi_wready,
    output logic [1:0]                           s00_axi_bresp,
    output logic                                 s00_axi_bvalid,
    input  logic                                 s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
    input  logic [2:0]                           s00_axi_arprot,
    input  logic                                 s00_axi_arvalid,
    output logic                                 s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
    output logic [1:0]                           s00_axi_rresp,
    output logic                                 s00_axi_rvalid,
    input  logic                                 s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef PL_BRAM_LITE_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DW-1:0]    regs [NUM_REGS];
    logic [IDX_W-1:0] aw_idx_q;
    logic [DW-1:0]    wdata_q;
    logic [SW-1:0]    wstrb_q;

    logic             aw_hs, w_hs, ar_hs;
    logic             commit, latch_aw, latch_w;
    logic [IDX_W-1:0] commit_idx, aw_idx_in, ar_idx;
    logic [DW-1:0]    commit_data;
    logic [SW-1:0]    commit_strb;
    logic             commit_hit, ar_hit;
    logic [DW-1:0]    ar_word;
    logic             unused_bits;

    // Byte-offset bits and protection attributes carry no meaning here.
    assign unused_bits = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign aw_hs     = s00_axi_awvalid & s00_axi_awready;
    assign w_hs      = s00_axi_wvalid  & s00_axi_wready;
    assign ar_hs     = s00_axi_arvalid & s00_axi_arready;
    assign aw_idx_in = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx    = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // Commit takes whichever half arrived now, the other half from the holding latch.
    always_comb begin
        w_next      = w_state;
        commit      = 1'b0;
        latch_aw    = 1'b0;
        latch_w     = 1'b0;
        commit_idx  = aw_idx_q;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    commit_idx  = aw_idx_in;
                    commit_data = s00_axi_wdata;
                    commit_strb = s00_axi_wstrb;
                    w_next      = W_RESP;
                end else if (aw_hs) begin
                    latch_aw = 1'b1;
                    w_next   = W_HAVE_AW;
                end else if (w_hs) begin
                    latch_w = 1'b1;
                    w_next  = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit      = 1'b1;
                    commit_data = s00_axi_wdata;
                    commit_strb = s00_axi_wstrb;
                    w_next      = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    commit_idx = aw_idx_in;
                    w_next     = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s00_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Address decode; anything not matching an implemented register reads as zero.
    always_comb begin
        commit_hit = 1'b0;
        ar_hit     = 1'b0;
        ar_word    = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_idx == IDX_W'(k)) commit_hit = 1'b1;
            if (ar_idx == IDX_W'(k)) begin
                ar_hit  = 1'b1;
                ar_word = regs[k];
            end
        end
    end

    // Handshake outputs are registered from the next state so they stay flop-driven.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state         <= W_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            aw_idx_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
        end else begin
            w_state         <= w_next;
            s00_axi_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
            s00_axi_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
            s00_axi_bvalid  <= (w_next == W_RESP);
            if (commit)   s00_axi_bresp <= commit_hit ? RESP_OKAY : RESP_OOR;
            if (latch_aw) aw_idx_q <= aw_idx_in;
            if (latch_w) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit_idx == IDX_W'(k)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (commit_strb[b]) regs[k][8*b +: 8] <= commit_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // rdata samples the array before any same-edge write lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            r_state         <= r_next;
            s00_axi_arready <= (r_next == R_IDLE);
            s00_axi_rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                s00_axi_rdata <= ar_word;
                s00_axi_rresp <= ar_hit ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[DW*k +: DW] = regs[k];
    end

endmodule

// File: tb/tb_pl_bram_lite_slave.sv
// Directed self-checking bench for pl_bram_lite_slave (default 4 registers, 5-bit address).
module tb_pl_bram_lite_slave;

`ifdef PL_BRAM_LITE_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif
    localparam int LIMIT = 20;

    logic         clock, reset;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] regs_o;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rd_data;
    logic [1:0]  rd_resp, wr_resp;

    pl_bram_lite_slave dut (
        .clock           (clock),
        .reset           (reset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .regs_o          (regs_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Full write with AW and W presented together and bready held high.
    task automatic apply_write(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int  cnt;
        logic aw_go, w_go;
        cnt = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && cnt < LIMIT) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            step();
            cnt++;
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        while (!bvalid && cnt < LIMIT) begin
            step();
            cnt++;
        end
        check_output("write_timeout", cnt < LIMIT, 1'b1);
        resp = bresp;
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        bready = 1'b0;
    endtask

    task automatic apply_read(input logic [4:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int  cnt;
        logic ar_go;
        cnt = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (arvalid && cnt < LIMIT) begin
            ar_go = arready;
            step();
            cnt++;
            if (ar_go) arvalid = 1'b0;
        end
        while (!rvalid && cnt < LIMIT) begin
            step();
            cnt++;
        end
        check_output("read_timeout", cnt < LIMIT, 1'b1);
        data = rdata;
        resp = rresp;
        arvalid = 1'b0;
        step();
        rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;

        repeat (5) step();
        check_output("rst_awready", awready, 1'b0);
        check_output("rst_wready", wready, 1'b0);
        check_output("rst_arready", arready, 1'b0);
        check_output("rst_bvalid", bvalid, 1'b0);
        check_output("rst_rvalid", rvalid, 1'b0);
        check_output("rst_resps", {bresp, rresp}, 4'b0000);
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_regs", regs_o, 128'h0);

        reset = 1'b0;
        step();
        check_output("post_rst_readies", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 4; i++) begin
            apply_write(5'(4 * i), 32'(i + 1), 4'hF, wr_resp);
            check_output("basic_bresp", wr_resp, 2'b00);
        end
        check_output("basic_regs", regs_o,
                     128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            apply_read(5'(4 * i), rd_data, rd_resp);
            check_output("basic_rdata", rd_data, 32'(i + 1));
            check_output("basic_rresp", rd_resp, 2'b00);
        end

        // AW first, W three edges later
        awaddr = 5'h08; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check_output("aw_first_readies", {awready, wready}, 2'b01);
        repeat (2) step();
        check_output("aw_first_no_bvalid", bvalid, 1'b0);
        check_output("aw_first_reg_old", regs_o[95:64], 32'h3);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check_output("aw_first_bvalid", bvalid, 1'b1);
        check_output("aw_first_reg", regs_o[95:64], 32'hDEADBEEF);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_output("aw_first_bvalid_done", bvalid, 1'b0);

        // W first, AW three edges later
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check_output("w_first_readies", {awready, wready}, 2'b10);
        repeat (2) step();
        check_output("w_first_no_bvalid", bvalid, 1'b0);
        awaddr = 5'h0C; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check_output("w_first_bvalid", bvalid, 1'b1);
        check_output("w_first_reg", regs_o[127:96], 32'hCAFEF00D);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_output("w_first_bvalid_done", bvalid, 1'b0);
        apply_read(5'h08, rd_data, rd_resp);
        check_output("split_rd_8", rd_data, 32'hDEADBEEF);
        apply_read(5'h0C, rd_data, rd_resp);
        check_output("split_rd_c", rd_data, 32'hCAFEF00D);

        apply_write(5'h04, 32'h11223344, 4'hF, wr_resp);
        apply_write(5'h04, 32'hAABBCCDD, 4'b0010, wr_resp);
        apply_read(5'h04, rd_data, rd_resp);
        check_output("strobe_rdata", rd_data, 32'h1122CC44);

        // Write response held off by bready
        awaddr = 5'h00; wdata = 32'h0000A5A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_output("bp_bvalid", bvalid, 1'b1);
            check_output("bp_bresp", bresp, 2'b00);
            check_output("bp_w_readies", {awready, wready}, 2'b00);
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_output("bp_bvalid_done", bvalid, 1'b0);
        check_output("bp_w_readies_back", {awready, wready}, 2'b11);

        // Read data held off by rready
        araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_output("bp_rvalid", rvalid, 1'b1);
            check_output("bp_rdata", rdata, 32'h0000A5A5);
            check_output("bp_arready", arready, 1'b0);
            step();
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        check_output("bp_rvalid_done", rvalid, 1'b0);
        check_output("bp_arready_back", arready, 1'b1);

        // Read and write commit to the same register on the same edge
        awaddr = 5'h00; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; araddr = 5'h00; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_output("same_cycle_valids", {bvalid, rvalid}, 2'b11);
        check_output("same_cycle_rdata_old", rdata, 32'h0000A5A5);
        check_output("same_cycle_reg_new", regs_o[31:0], 32'h12345678);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        check_output("same_cycle_done", {bvalid, rvalid}, 2'b00);

        apply_write(5'h10, 32'h00000055, 4'hF, wr_resp);
        check_output("oor_bresp", wr_resp, EXP_OOR);
        check_output("oor_regs", regs_o,
                     128'hCAFEF00D_DEADBEEF_1122CC44_12345678);
        apply_read(5'h10, rd_data, rd_resp);
        check_output("oor_rdata", rd_data, 32'h0);
        check_output("oor_rresp", rd_resp, EXP_OOR);

        apply_read(5'h06, rd_data, rd_resp);
        check_output("unaligned_rdata", rd_data, 32'h1122CC44);
        check_output("unaligned_rresp", rd_resp, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
